// File: rtl/timer_counter_if.sv
// Control and status signals between the timer register block (master) and the timer core (slave).
interface timer_counter_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             load;
    logic             updown;
    logic [1:0]       cks;
    logic [CNT_W-1:0] tdr;
    logic [CNT_W-1:0] cnt;
    logic             ovf_trig;
    logic             udf_trig;

    modport master (
        output en, load, updown, cks, tdr,
        input  cnt, ovf_trig, udf_trig
    );

    modport slave (
        input  en, load, updown, cks, tdr,
        output cnt, ovf_trig, udf_trig
    );
endinterface

// File: rtl/timer_counter.sv
// 8-bit up/down prescaled timer core with registered one-cycle overflow/underflow pulses.
// Define TIMER_PRESCALE_EN to build the cks-selected prescaler; otherwise the counter steps every enabled pclk.
module timer_counter #(
    parameter int CNT_W = 8,
    parameter int PRE_W = 4
) (
    input  logic            pclk,
    input  logic            preset_n,
    timer_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             udf_q;
    logic             tick;

`ifdef TIMER_PRESCALE_EN
    localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_mask;

    // cks selects how many low prescaler bits must all be set: /2, /4, /8, /16
    always_comb begin
        pre_mask = '0;
        for (int i = 0; i < PRE_W; i++) begin
            pre_mask[i] = (i <= int'(bus.cks));
        end
    end

    assign tick = bus.en && !bus.load && ((pre & pre_mask) == pre_mask);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pre <= '0;
        end else if (bus.load) begin
            pre <= '0;
        end else if (bus.en) begin
            pre <= pre + PRE_ONE;
        end
    end
`else
    logic unused_cks;

    assign unused_cks = ^bus.cks;
    assign tick       = bus.en && !bus.load;
`endif

    // Load overrides counting; a wrap is flagged in the cycle after the wrapping edge
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            if (bus.load) begin
                cnt_q <= bus.tdr;
            end else if (tick) begin
                if (!bus.updown) begin
                    cnt_q <= cnt_q + CNT_ONE;
                    ovf_q <= (cnt_q == {CNT_W{1'b1}});
                end else begin
                    cnt_q <= cnt_q - CNT_ONE;
                    udf_q <= (cnt_q == {CNT_W{1'b0}});
                end
            end
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.ovf_trig = ovf_q;
    assign bus.udf_trig = udf_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus random traffic against a cycle-level arithmetic model.
module tb_timer_counter;

    logic pclk;
    logic preset_n;

    timer_counter_if #(.CNT_W(8)) bus ();

    timer_counter #(.CNT_W(8), .PRE_W(4)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    // Reference model: counter value as an integer, count of enabled cycles since load
    int m_cnt = 0;
    int m_pre = 0;
    bit m_ovf = 0;
    bit m_udf = 0;

    function automatic int period_of(input logic [1:0] ck);
`ifdef TIMER_PRESCALE_EN
        return 2 << ck;
`else
        return 1;
`endif
    endfunction

    function automatic bit model_tick(input bit en, input bit ld, input logic [1:0] ck);
        return en && !ld && ((m_pre % period_of(ck)) == period_of(ck) - 1);
    endfunction

    task automatic applyStimulus(input bit rst_n, input bit en, input bit ld, input bit ud,
                                 input logic [1:0] ck, input logic [7:0] td);
        bit t;
        preset_n   = rst_n;
        bus.en     = en;
        bus.load   = ld;
        bus.updown = ud;
        bus.cks    = ck;
        bus.tdr    = td;
        @(posedge pclk);
        t = model_tick(en, ld, ck);
        m_ovf = 0;
        m_udf = 0;
        if (!rst_n) begin
            m_cnt = 0;
            m_pre = 0;
        end else if (ld) begin
            m_cnt = int'(td);
            m_pre = 0;
        end else if (en) begin
            m_pre = (m_pre + 1) % 16;
            if (t) begin
                m_ovf = !ud && (m_cnt == 255);
                m_udf = ud && (m_cnt == 0);
                m_cnt = ud ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 8'hAB);
            total += 3;
            if (bus.cnt !== 8'h00) begin bad++; $display("[TB] FAIL reset_cnt got=%h want=00", bus.cnt); end
            if (bus.ovf_trig !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%b want=0", bus.ovf_trig); end
            if (bus.udf_trig !== 1'b0) begin bad++; $display("[TB] FAIL reset_udf got=%b want=0", bus.udf_trig); end
        end
    endtask

    task automatic test_wrap_up();
        int pulses = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'hFD);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'hFD);
        total++;
        if (bus.cnt !== 8'hFD) begin bad++; $display("[TB] FAIL wrap_up_load got=%h want=FD", bus.cnt); end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h33);
            pulses += int'(bus.ovf_trig);
            total += 2;
            if (bus.cnt !== 8'(m_cnt)) begin bad++; $display("[TB] FAIL wrap_up_cnt got=%h want=%h", bus.cnt, 8'(m_cnt)); end
            if (bus.ovf_trig !== m_ovf) begin bad++; $display("[TB] FAIL wrap_up_ovf got=%b want=%b", bus.ovf_trig, m_ovf); end
        end
        total++;
        if (pulses != 1) begin bad++; $display("[TB] FAIL wrap_up_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_wrap_down();
        int pulses = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 8'h01);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 8'h77);
            pulses += int'(bus.udf_trig);
            total += 3;
            if (bus.cnt !== 8'(m_cnt)) begin bad++; $display("[TB] FAIL wrap_down_cnt got=%h want=%h", bus.cnt, 8'(m_cnt)); end
            if (bus.udf_trig !== m_udf) begin bad++; $display("[TB] FAIL wrap_down_udf got=%b want=%b", bus.udf_trig, m_udf); end
            if (bus.ovf_trig !== 1'b0) begin bad++; $display("[TB] FAIL wrap_down_ovf got=%b want=0", bus.ovf_trig); end
        end
        total++;
        if (pulses != 1) begin bad++; $display("[TB] FAIL wrap_down_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_enable_gap();
        bit en;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 8'h20);
        for (int i = 0; i < 20; i++) begin
            en = !(i >= 2 && i < 7);
            applyStimulus(1'b1, en, 1'b0, 1'b0, 2'b01, 8'h99);
            total += 2;
            if (bus.cnt !== 8'(m_cnt)) begin bad++; $display("[TB] FAIL enable_gap_cnt cyc=%0d got=%h want=%h", i, bus.cnt, 8'(m_cnt)); end
            if (bus.ovf_trig !== m_ovf) begin bad++; $display("[TB] FAIL enable_gap_ovf got=%b want=%b", bus.ovf_trig, m_ovf); end
        end
    endtask

    task automatic test_load_on_wrap();
        int guard = 0;
        int start;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'hFF);
        while (!model_tick(1'b1, 1'b0, 2'b00) && guard < 20) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h10);
            guard++;
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 8'h10);
        total += 2;
        if (bus.cnt !== 8'h10) begin bad++; $display("[TB] FAIL load_on_wrap_cnt got=%h want=10", bus.cnt); end
        if (bus.ovf_trig !== 1'b0) begin bad++; $display("[TB] FAIL load_on_wrap_ovf got=%b want=0", bus.ovf_trig); end
        start = 0;
        while (bus.cnt === 8'h10 && start < 40) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 8'h55);
            start++;
        end
        total += 2;
        if (bus.cnt !== 8'h0F) begin bad++; $display("[TB] FAIL flip_dir_cnt got=%h want=0F", bus.cnt); end
        if (bus.udf_trig !== 1'b0 || bus.ovf_trig !== 1'b0) begin
            bad++; $display("[TB] FAIL flip_dir_trig got=%b%b want=00", bus.ovf_trig, bus.udf_trig);
        end
    endtask

    task automatic test_reset_midcount();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h80);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h80);
        #2;
        preset_n = 1'b0;
        m_cnt = 0; m_pre = 0; m_ovf = 0; m_udf = 0;
        #1;
        total++;
        if (bus.cnt !== 8'h00) begin bad++; $display("[TB] FAIL async_reset_cnt got=%h want=00", bus.cnt); end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h80);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h80);
            total++;
            if (bus.cnt !== 8'(m_cnt)) begin bad++; $display("[TB] FAIL post_reset_cnt got=%h want=%h", bus.cnt, 8'(m_cnt)); end
        end
    endtask

    task automatic test_random();
        bit en, ld, ud;
        logic [1:0] ck = 2'b00;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 3) != 0);
            ud = ($urandom_range(0, 63) < 20) ? !bus.updown : bus.updown;
            if ($urandom_range(0, 31) == 0) ck = 2'($urandom_range(0, 3));
            applyStimulus(1'b1, en, ld, ud, ck, 8'($urandom_range(0, 255)));
            total += 4;
            if (bus.cnt !== 8'(m_cnt)) begin bad++; $display("[TB] FAIL random_cnt cyc=%0d got=%h want=%h", i, bus.cnt, 8'(m_cnt)); end
            if (bus.ovf_trig !== m_ovf) begin bad++; $display("[TB] FAIL random_ovf cyc=%0d got=%b want=%b", i, bus.ovf_trig, m_ovf); end
            if (bus.udf_trig !== m_udf) begin bad++; $display("[TB] FAIL random_udf cyc=%0d got=%b want=%b", i, bus.udf_trig, m_udf); end
            if (bus.ovf_trig === 1'b1 && bus.udf_trig === 1'b1) begin bad++; $display("[TB] FAIL random_both_trig got=11 want=not both"); end
        end
    endtask

    initial begin
        preset_n   = 1'b0;
        bus.en     = 1'b0;
        bus.load   = 1'b0;
        bus.updown = 1'b0;
        bus.cks    = 2'b00;
        bus.tdr    = 8'h00;
        $display("[TB] starting timer_counter bench");
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_enable_gap();
        test_load_on_wrap();
        test_reset_midcount();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
